periph_bus_bridge: RTL and testbench
====================================

// Module: periph_bus_bridge
// PURPOSE
// - Single-master bus bridge between the multicycle core's load/store unit and its slaves.
// - Slaves are the data RAM and the 7-segment peripheral (read/write/addr/wdata -> valid/rdata).
// - Decodes the CPU address and issues a one-cycle registered read/write strobe to the selected slave.
// - Waits for the slave's valid on reads, then returns a one-cycle cpu_ready pulse with rdata or an error flag.
// PARAMETERS
// - RAM_AW          10             RAM word-address width (RAM occupies bytes 0 .. 4*2**RAM_AW-1)
// - SEG_BASE        32'h8000_0000  base of the 8-byte 7-seg window (+0 control, +4 data)
// - TIMEOUT_CYCLES  16             read wait limit in cycles; used only with BUS_TIMEOUT_EN
// PORTS
// - clk           in   1         clock
// - rst           in   1         asynchronous reset, active-high
// - cpu_read      in   1         read request; held until cpu_ready
// - cpu_write     in   1         write request; held until cpu_ready
// - cpu_addr      in   32        byte address; [1:0] ignored
// - cpu_wdata     in   32        write data
// - cpu_byteena   in   4         write byte enables (forwarded to RAM only)
// - cpu_rdata     out  32        read data; valid while cpu_ready=1
// - cpu_ready     out  1         one-cycle completion pulse
// - cpu_err       out  1         qualifies cpu_ready: unmapped address or timeout
// - ram_read      out  1         one-cycle RAM read strobe
// - ram_write     out  1         one-cycle RAM write strobe
// - ram_addr      out  RAM_AW    word address = cpu_addr[RAM_AW+1:2]
// - ram_wdata     out  32        RAM write data
// - ram_byteena   out  4         RAM byte enables
// - ram_valid     in   1         RAM read data valid
// - ram_rdata     in   32        RAM read data
// - seg_read      out  1         one-cycle 7-seg read strobe
// - seg_write     out  1         one-cycle 7-seg write strobe
// - seg_addr      out  1         cpu_addr[2]: 1 = data register, 0 = control register
// - seg_wdata     out  32        7-seg write data
// - seg_valid     in   1         7-seg read data valid
// - seg_rdata     in   32        7-seg read data
// BEHAVIOUR
// - All outputs are registered. On reset every output is 0 and the state is IDLE.
// - Reset mid-transaction aborts it: no ready is issued and the CPU must re-request.
// - Decode:
//   - RAM: cpu_addr[31:RAM_AW+2] == 0.
//   - SEG: cpu_addr[31:3] == SEG_BASE[31:3].
//   - Anything else is unmapped.
// - FSM states: IDLE, WR, RD, RESP.
// - IDLE, on cpu_read or cpu_write:
//   - cpu_read has priority if both are asserted.
//   - Mapped address: latch target, addr, wdata and byteena; assert the target strobe for the next cycle; go to RD or WR.
//   - Unmapped address: go to RESP with cpu_err=1 and cpu_rdata=0. No slave strobe.
// - WR: strobe is high this cycle only; go to RESP. Slave valid is not awaited.
//   - Write latency: request seen at cycle 0 -> strobe at cycle 1 -> cpu_ready at cycle 2.
// - RD: strobe is high only in the first RD cycle. Wait for the selected slave's valid.
//   - On valid, capture its rdata and go to RESP.
//   - Minimum read latency: cycle 0 request -> cycle 1 strobe -> cycle 2 valid -> cycle 3 cpu_ready.
// - RESP: cpu_ready=1 for exactly one cycle, then IDLE.
//   - cpu_rdata holds the captured value until the next RESP.
//   - cpu_err is cleared on the next request.
// - The CPU drops or changes its request on the edge at which it sees cpu_ready. IDLE samples the next request one cycle after RESP.
// - The non-selected slave's valid, and any valid outside RD, are ignored.
// - Slave rdata is captured only on the valid cycle.
// CONFIGURATION
// - BUS_TIMEOUT_EN defined:
//   - RD counts cycles from 0.
//   - If no valid arrives by count TIMEOUT_CYCLES-1, go to RESP with cpu_err=1 and cpu_rdata=0.
//   - A valid arriving on the same cycle as the timeout wins: data is returned with err=0.
// - BUS_TIMEOUT_EN undefined: no counter; RD waits indefinitely.
// TESTING
// - Write 32'h0000_0001 to 0x8000_0000 -> seg_write=1 and seg_addr=0 at cycle 1; cpu_ready=1, cpu_err=0 at cycle 2.
// - Write 32'h0012_3456 to 0x8000_0004, then read 0x8000_0004 -> seg_read pulse one cycle wide; cpu_rdata=32'h0012_3456 with cpu_ready at cycle 3.
// - Write 0xCAFEF00D to 0x0000_0010 with byteena=4'b0011 -> ram_addr=4, ram_byteena=4'b0011, ram_write one cycle; no seg strobe.
// - Read 0x4000_0000 -> no strobe on either slave; cpu_ready with cpu_err=1 and cpu_rdata=0 at cycle 1.
// - cpu_read and cpu_write both high to 0x8000_0004 -> read is performed and seg_write stays 0.
// - BUS_TIMEOUT_EN, read RAM with ram_valid held 0 -> cpu_err=1 after 16 RD cycles; then assert rst mid-RD -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/periph_bus_bridge_if.sv
// Bus bundle between the load/store unit, the bridge and its two slaves (data RAM, 7-seg).
// The master modport is the environment view (CPU plus slave devices); the slave modport is the bridge view.
interface periph_bus_bridge_if #(
    parameter int RAM_AW = 10
);
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_byteena;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;

    logic              ram_read;
    logic              ram_write;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_byteena;
    logic              ram_valid;
    logic [31:0]       ram_rdata;

    logic              seg_read;
    logic              seg_write;
    logic              seg_addr;
    logic [31:0]       seg_wdata;
    logic              seg_valid;
    logic [31:0]       seg_rdata;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_byteena,
        output ram_valid, ram_rdata, seg_valid, seg_rdata,
        input  cpu_rdata, cpu_ready, cpu_err,
        input  ram_read, ram_write, ram_addr, ram_wdata, ram_byteena,
        input  seg_read, seg_write, seg_addr, seg_wdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_byteena,
        input  ram_valid, ram_rdata, seg_valid, seg_rdata,
        output cpu_rdata, cpu_ready, cpu_err,
        output ram_read, ram_write, ram_addr, ram_wdata, ram_byteena,
        output seg_read, seg_write, seg_addr, seg_wdata
    );
endinterface

// File: rtl/periph_bus_bridge.sv
// Single-master bridge from the load/store unit to the data RAM and 7-seg peripheral; all outputs registered.
// Optional read timeout is enabled by defining BUS_TIMEOUT_EN.
module periph_bus_bridge #(
    parameter int          RAM_AW         = 10,
    parameter logic [31:0] SEG_BASE       = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    periph_bus_bridge_if.slave bus_io
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic              tgtSeg_q, tgtSeg_d;
    logic              ramRead_q, ramRead_d;
    logic              ramWrite_q, ramWrite_d;
    logic [RAM_AW-1:0] ramAddr_q, ramAddr_d;
    logic [31:0]       ramWdata_q, ramWdata_d;
    logic [3:0]        ramByteena_q, ramByteena_d;
    logic              segRead_q, segRead_d;
    logic              segWrite_q, segWrite_d;
    logic              segAddr_q, segAddr_d;
    logic [31:0]       segWdata_q, segWdata_d;
    logic [31:0]       cpuRdata_q, cpuRdata_d;
    logic              cpuReady_q, cpuReady_d;
    logic              cpuErr_q, cpuErr_d;

    logic              reqAny;
    logic              hitRam;
    logic              hitSeg;
    logic              slaveValid;
    logic [31:0]       slaveRdata;
    logic              timeout;
    logic              unusedAddrBits;

    assign reqAny         = bus_io.cpu_read | bus_io.cpu_write;
    assign hitRam         = (bus_io.cpu_addr[31:RAM_AW+2] == '0);
    assign hitSeg         = (bus_io.cpu_addr[31:3] == SEG_BASE[31:3]);
    assign unusedAddrBits = ^bus_io.cpu_addr[1:0];

    // Only the slave latched at request time may complete a read.
    assign slaveValid = tgtSeg_q ? bus_io.seg_valid : bus_io.ram_valid;
    assign slaveRdata = tgtSeg_q ? bus_io.seg_rdata : bus_io.ram_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    assign timeout = (count_q == CW'(TIMEOUT_CYCLES - 1));
    assign count_d = (state_q == RD) ? count_q + CW'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tgtSeg_q     <= 1'b0;
            ramRead_q    <= 1'b0;
            ramWrite_q   <= 1'b0;
            ramAddr_q    <= '0;
            ramWdata_q   <= '0;
            ramByteena_q <= '0;
            segRead_q    <= 1'b0;
            segWrite_q   <= 1'b0;
            segAddr_q    <= 1'b0;
            segWdata_q   <= '0;
            cpuRdata_q   <= '0;
            cpuReady_q   <= 1'b0;
            cpuErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgtSeg_q     <= tgtSeg_d;
            ramRead_q    <= ramRead_d;
            ramWrite_q   <= ramWrite_d;
            ramAddr_q    <= ramAddr_d;
            ramWdata_q   <= ramWdata_d;
            ramByteena_q <= ramByteena_d;
            segRead_q    <= segRead_d;
            segWrite_q   <= segWrite_d;
            segAddr_q    <= segAddr_d;
            segWdata_q   <= segWdata_d;
            cpuRdata_q   <= cpuRdata_d;
            cpuReady_q   <= cpuReady_d;
            cpuErr_q     <= cpuErr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (reqAny) begin
                    if (hitRam || hitSeg) begin
                        state_d = bus_io.cpu_read ? RD : WR;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WR:   state_d = RESP;
            RD: begin
                if (slaveValid || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead so each strobe/ready lands on its own cycle.
    always_comb begin
        tgtSeg_d     = tgtSeg_q;
        ramRead_d    = 1'b0;
        ramWrite_d   = 1'b0;
        ramAddr_d    = ramAddr_q;
        ramWdata_d   = ramWdata_q;
        ramByteena_d = ramByteena_q;
        segRead_d    = 1'b0;
        segWrite_d   = 1'b0;
        segAddr_d    = segAddr_q;
        segWdata_d   = segWdata_q;
        cpuRdata_d   = cpuRdata_q;
        cpuReady_d   = 1'b0;
        cpuErr_d     = cpuErr_q;

        unique case (state_q)
            IDLE: begin
                if (reqAny) begin
                    cpuErr_d = 1'b0;
                    if (hitRam) begin
                        tgtSeg_d     = 1'b0;
                        ramAddr_d    = bus_io.cpu_addr[RAM_AW+1:2];
                        ramWdata_d   = bus_io.cpu_wdata;
                        ramByteena_d = bus_io.cpu_byteena;
                        ramRead_d    = bus_io.cpu_read;
                        ramWrite_d   = ~bus_io.cpu_read;
                    end else if (hitSeg) begin
                        tgtSeg_d     = 1'b1;
                        segAddr_d    = bus_io.cpu_addr[2];
                        segWdata_d   = bus_io.cpu_wdata;
                        segRead_d    = bus_io.cpu_read;
                        segWrite_d   = ~bus_io.cpu_read;
                    end else begin
                        cpuErr_d   = 1'b1;
                        cpuRdata_d = '0;
                        cpuReady_d = 1'b1;
                    end
                end
            end
            WR: begin
                cpuReady_d = 1'b1;
            end
            RD: begin
                // A valid on the timeout cycle still returns data.
                if (slaveValid) begin
                    cpuRdata_d = slaveRdata;
                    cpuReady_d = 1'b1;
                end else if (timeout) begin
                    cpuRdata_d = '0;
                    cpuErr_d   = 1'b1;
                    cpuReady_d = 1'b1;
                end
            end
            RESP: begin
                cpuReady_d = 1'b0;
            end
            default: begin
                cpuReady_d = 1'b0;
            end
        endcase
    end

    assign bus_io.cpu_rdata   = cpuRdata_q;
    assign bus_io.cpu_ready   = cpuReady_q;
    assign bus_io.cpu_err     = cpuErr_q;
    assign bus_io.ram_read    = ramRead_q;
    assign bus_io.ram_write   = ramWrite_q;
    assign bus_io.ram_addr    = ramAddr_q;
    assign bus_io.ram_wdata   = ramWdata_q;
    assign bus_io.ram_byteena = ramByteena_q;
    assign bus_io.seg_read    = segRead_q;
    assign bus_io.seg_write   = segWrite_q;
    assign bus_io.seg_addr    = segAddr_q;
    assign bus_io.seg_wdata   = segWdata_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: vector table plus hand-written reset/timeout sequences.
// Behavioural RAM and 7-seg slaves with programmable read latency sit on the slave side.
module tb_periph_bus_bridge;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        bit          expErr;
        logic [31:0] expRdata;
        int          expCycles;
        int          expRamRd;
        int          expRamWr;
        int          expSegRd;
        int          expSegWr;
        int          expRamAddr;
        int          expSegAddr;
    } vec_t;

    typedef struct {
        string       name;
        bit          err;
        logic [31:0] rdata;
        bit          chkRd;
        int          cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    periph_bus_bridge_if #(.RAM_AW(10)) bus ();

    periph_bus_bridge #(
        .RAM_AW        (10),
        .SEG_BASE      (32'h8000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          slaveLat = 0;
    bit          ramMute = 1'b0;
    bit          spurSeg = 1'b0;
    exp_t        sbq[$];
    vec_t        vecs[$];

    logic [31:0] ramMem [0:1023];
    logic [9:0]  ramPendAddr = '0;
    int          ramWait = 0;
    logic [31:0] segRegs [0:1];
    logic        segPendAddr = 1'b0;
    int          segWait = 0;

    int          ramRdCnt = 0;
    int          ramWrCnt = 0;
    int          segRdCnt = 0;
    int          segWrCnt = 0;
    int          strobeCyc = 0;
    logic [9:0]  ramAddrSeen = '0;
    logic [31:0] ramWdataSeen = '0;
    logic [3:0]  ramBeSeen = '0;
    logic        segAddrSeen = 1'b0;
    logic [31:0] segWdataSeen = '0;

    initial begin
        for (int i = 0; i < 1024; i++) ramMem[i] = '0;
        segRegs[0] = '0;
        segRegs[1] = '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: byte-enabled writes, read data after slaveLat extra cycles, junk rdata otherwise.
    always @(posedge clk) begin
        bus.ram_valid <= 1'b0;
        bus.ram_rdata <= $urandom;
        if (bus.ram_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_byteena[b]) ramMem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
        end
        if (bus.ram_read && !ramMute) begin
            ramPendAddr <= bus.ram_addr;
            if (slaveLat == 0) begin
                bus.ram_valid <= 1'b1;
                bus.ram_rdata <= ramMem[bus.ram_addr];
            end else begin
                ramWait <= slaveLat;
            end
        end else if (ramWait > 0) begin
            ramWait <= ramWait - 1;
            if (ramWait == 1) begin
                bus.ram_valid <= 1'b1;
                bus.ram_rdata <= ramMem[ramPendAddr];
            end
        end
    end

    always @(posedge clk) begin
        bus.seg_valid <= spurSeg;
        bus.seg_rdata <= $urandom;
        if (bus.seg_write) segRegs[bus.seg_addr] <= bus.seg_wdata;
        if (bus.seg_read) begin
            segPendAddr <= bus.seg_addr;
            if (slaveLat == 0) begin
                bus.seg_valid <= 1'b1;
                bus.seg_rdata <= segRegs[bus.seg_addr];
            end else begin
                segWait <= slaveLat;
            end
        end else if (segWait > 0) begin
            segWait <= segWait - 1;
            if (segWait == 1) begin
                bus.seg_valid <= 1'b1;
                bus.seg_rdata <= segRegs[segPendAddr];
            end
        end
    end

    always @(negedge clk) begin
        if (bus.ram_read) begin
            ramRdCnt    <= ramRdCnt + 1;
            ramAddrSeen <= bus.ram_addr;
            strobeCyc   <= cyc;
        end
        if (bus.ram_write) begin
            ramWrCnt     <= ramWrCnt + 1;
            ramAddrSeen  <= bus.ram_addr;
            ramWdataSeen <= bus.ram_wdata;
            ramBeSeen    <= bus.ram_byteena;
            strobeCyc    <= cyc;
        end
        if (bus.seg_read) begin
            segRdCnt    <= segRdCnt + 1;
            segAddrSeen <= bus.seg_addr;
            strobeCyc   <= cyc;
        end
        if (bus.seg_write) begin
            segWrCnt     <= segWrCnt + 1;
            segAddrSeen  <= bus.seg_addr;
            segWdataSeen <= bus.seg_wdata;
            strobeCyc    <= cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input string n, input bit rd, input bit wr, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] be, input int lat,
                                   input bit err, input logic [31:0] rdat, input int cycles,
                                   input int rr, input int rw, input int sr, input int sw,
                                   input int rAddr, input int sAddr);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.be = be; v.lat = lat;
        v.expErr = err; v.expRdata = rdat; v.expCycles = cycles;
        v.expRamRd = rr; v.expRamWr = rw; v.expSegRd = sr; v.expSegWr = sw;
        v.expRamAddr = rAddr; v.expSegAddr = sAddr;
        return v;
    endfunction

    // Drives one request, scoreboards the response and checks the slave-side strobes it caused.
    task automatic applyStimulus(input vec_t v);
        int   startCyc;
        int   rr0, rw0, sr0, sw0;
        bit   got;
        exp_t e;
        @(negedge clk);
        slaveLat        = v.lat;
        bus.cpu_read    = v.rd;
        bus.cpu_write   = v.wr;
        bus.cpu_addr    = v.addr;
        bus.cpu_wdata   = v.wdata;
        bus.cpu_byteena = v.be;
        sbq.push_back('{name: v.name, err: v.expErr, rdata: v.expRdata, chkRd: v.rd, cycles: v.expCycles});
        startCyc = cyc;
        rr0 = ramRdCnt; rw0 = ramWrCnt; sr0 = segRdCnt; sw0 = segWrCnt;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.cpu_ready) got = 1'b1;
        end
        e = sbq.pop_front();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s ready: got no cpu_ready within 200 cycles expected one", e.name);
        end else begin
            checkOutput({e.name, " err"}, 32'(bus.cpu_err), 32'(e.err));
            if (e.chkRd) checkOutput({e.name, " rdata"}, bus.cpu_rdata, e.rdata);
            checkOutput({e.name, " latency"}, 32'(cyc - startCyc), 32'(e.cycles));
        end
        checkOutput({v.name, " ram_read count"},  32'(ramRdCnt - rr0), 32'(v.expRamRd));
        checkOutput({v.name, " ram_write count"}, 32'(ramWrCnt - rw0), 32'(v.expRamWr));
        checkOutput({v.name, " seg_read count"},  32'(segRdCnt - sr0), 32'(v.expSegRd));
        checkOutput({v.name, " seg_write count"}, 32'(segWrCnt - sw0), 32'(v.expSegWr));
        if (v.expRamRd + v.expRamWr + v.expSegRd + v.expSegWr > 0)
            checkOutput({v.name, " strobe cycle"}, 32'(strobeCyc - startCyc), 32'd1);
        if (v.expRamAddr >= 0) checkOutput({v.name, " ram_addr"}, 32'(ramAddrSeen), 32'(v.expRamAddr));
        if (v.expRamWr > 0) begin
            checkOutput({v.name, " ram_wdata"}, ramWdataSeen, v.wdata);
            checkOutput({v.name, " ram_byteena"}, 32'(ramBeSeen), 32'(v.be));
        end
        if (v.expSegAddr >= 0) checkOutput({v.name, " seg_addr"}, 32'(segAddrSeen), 32'(v.expSegAddr));
        if (v.expSegWr > 0) checkOutput({v.name, " seg_wdata"}, segWdataSeen, v.wdata);
        @(negedge clk);
        checkOutput({v.name, " ready one cycle"}, 32'(bus.cpu_ready), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " cpu_ready"},   32'(bus.cpu_ready), 32'd0);
        checkOutput({tag, " cpu_err"},     32'(bus.cpu_err), 32'd0);
        checkOutput({tag, " cpu_rdata"},   bus.cpu_rdata, 32'd0);
        checkOutput({tag, " ram strobes"}, 32'({bus.ram_read, bus.ram_write}), 32'd0);
        checkOutput({tag, " ram_addr"},    32'(bus.ram_addr), 32'd0);
        checkOutput({tag, " ram_wdata"},   bus.ram_wdata, 32'd0);
        checkOutput({tag, " ram_byteena"}, 32'(bus.ram_byteena), 32'd0);
        checkOutput({tag, " seg strobes"}, 32'({bus.seg_read, bus.seg_write, bus.seg_addr}), 32'd0);
        checkOutput({tag, " seg_wdata"},   bus.seg_wdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int readyCnt;
        int rr0;
        bus.cpu_read    = 1'b0;
        bus.cpu_write   = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.cpu_byteena = '0;

        #2 rst = 1'b1;
        #1 checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //                 name               rd wr addr           wdata          be      lat err rdata          cyc rr rw sr sw ramA  segA
        vecs.push_back(mkVec("seg ctrl write",  0, 1, 32'h8000_0000, 32'h0000_0001, 4'hF,    0, 0, 32'h0,         2, 0, 0, 0, 1, -1,   0));
        vecs.push_back(mkVec("seg data write",  0, 1, 32'h8000_0004, 32'h0012_3456, 4'hF,    0, 0, 32'h0,         2, 0, 0, 0, 1, -1,   1));
        vecs.push_back(mkVec("seg data read",   1, 0, 32'h8000_0004, 32'h0,         4'h0,    0, 0, 32'h0012_3456, 3, 0, 0, 1, 0, -1,   1));
        vecs.push_back(mkVec("ram write be3",   0, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'b0011, 0, 0, 32'h0,         2, 0, 1, 0, 0, 4,    -1));
        vecs.push_back(mkVec("ram read lat2",   1, 0, 32'h0000_0010, 32'h0,         4'h0,    2, 0, 32'h0000_F00D, 5, 1, 0, 0, 0, 4,    -1));
        vecs.push_back(mkVec("unmapped read",   1, 0, 32'h4000_0000, 32'h0,         4'h0,    0, 1, 32'h0,         1, 0, 0, 0, 0, -1,   -1));
        vecs.push_back(mkVec("ram top write",   0, 1, 32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF,    0, 0, 32'h0,         2, 0, 1, 0, 0, 1023, -1));
        vecs.push_back(mkVec("ram top read",    1, 0, 32'h0000_0FFC, 32'h0,         4'h0,    1, 0, 32'hDEAD_BEEF, 4, 1, 0, 0, 0, 1023, -1));
        vecs.push_back(mkVec("past ram read",   1, 0, 32'h0000_1000, 32'h0,         4'h0,    0, 1, 32'h0,         1, 0, 0, 0, 0, -1,   -1));
        vecs.push_back(mkVec("past seg read",   1, 0, 32'h8000_0008, 32'h0,         4'h0,    0, 1, 32'h0,         1, 0, 0, 0, 0, -1,   -1));
        vecs.push_back(mkVec("seg ctrl read",   1, 0, 32'h8000_0000, 32'h0,         4'h0,    3, 0, 32'h0000_0001, 6, 0, 0, 1, 0, -1,   0));
        vecs.push_back(mkVec("read beats wr",   1, 1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF,    0, 0, 32'h0012_3456, 3, 0, 0, 1, 0, -1,   1));
        vecs.push_back(mkVec("unmapped write",  0, 1, 32'h7FFF_FFFC, 32'h1111_2222, 4'hF,    0, 1, 32'h0,         1, 0, 0, 0, 0, -1,   -1));
        vecs.push_back(mkVec("ram low bits",    1, 0, 32'h0000_0013, 32'h0,         4'h0,    1, 0, 32'h0000_F00D, 4, 1, 0, 0, 0, 4,    -1));

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        spurSeg = 1'b1;
        applyStimulus(mkVec("ram read seg noise", 1, 0, 32'h0000_0FFC, 32'h0, 4'h0, 3, 0, 32'hDEAD_BEEF, 6, 1, 0, 0, 0, 1023, -1));
        spurSeg = 1'b0;

`ifdef BUS_TIMEOUT_EN
        ramMute = 1'b1;
        applyStimulus(mkVec("ram read timeout", 1, 0, 32'h0000_0020, 32'h0, 4'h0, 0, 1, 32'h0, 17, 1, 0, 0, 0, 8, -1));
        ramMute = 1'b0;
        applyStimulus(mkVec("valid on timeout", 1, 0, 32'h0000_0010, 32'h0, 4'h0, 14, 0, 32'h0000_F00D, 17, 1, 0, 0, 0, 4, -1));
`else
        applyStimulus(mkVec("long ram wait", 1, 0, 32'h0000_0010, 32'h0, 4'h0, 20, 0, 32'h0000_F00D, 23, 1, 0, 0, 0, 4, -1));
`endif

        // Reset in the middle of a read whose slave never answers.
        ramMute = 1'b1;
        @(negedge clk);
        rr0 = ramRdCnt;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h0000_0020;
        repeat (4) @(negedge clk);
        checkOutput("mid-read ram_read issued", 32'(ramRdCnt - rr0), 32'd1);
        rst = 1'b1;
        #1 checkAllZero("mid-read reset");
        bus.cpu_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        readyCnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.cpu_ready) readyCnt++;
        end
        checkOutput("no ready after abort", 32'(readyCnt), 32'd0);
        ramMute = 1'b0;
        applyStimulus(mkVec("write after reset", 0, 1, 32'h8000_0000, 32'h0000_005A, 4'hF, 0, 0, 32'h0, 2, 0, 0, 0, 1, -1, 0));
        applyStimulus(mkVec("read after reset",  1, 0, 32'h8000_0000, 32'h0, 4'h0, 1, 0, 32'h0000_005A, 4, 0, 0, 1, 0, -1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
